adc_capture_ctrl: RTL

ADC_CAPTURE_CTRL -- requirements
Module: adc_capture_ctrl

---
 rtl/adc_capture_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/adc_capture_ctrl.sv
`timescale 1ns/1ps
// adc_capture_ctrl
// Arms on a start pulse, waits for a level trigger, then streams packed
// dual-channel ADC samples into a FIFO at a decimated rate until a
// programmed word count is reached (or forever when capture_len = 0).
//
// Ports
//   clk, rst_n          clock, async active-low reset
//   adc_1_data/adc_2_data  14-bit samples, valid every cycle
//   start, trig, abort  control: arm pulse, level trigger, cancel pulse
//   capture_len, decim  configuration, latched on start
//   fifo_wdata/wr_en    FIFO write port, fifo_full back-pressure flag
//   busy, done          status: armed/capturing, completion pulse
//   overflow            sticky: a sample event hit a full FIFO
//   words_written       words accepted in the current or last capture
//
// state   | meaning
// IDLE    | waiting for start
// ARMED   | config latched, waiting for trig
// CAPTURE | producing sample events every decim+1 cycles
// DONE    | capture_len words accepted, done pulse this cycle
module adc_capture_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [13:0] adc_1_data,
   input  logic [13:0] adc_2_data,
   input  logic        start,
   input  logic        trig,
   input  logic        abort,
   input  logic [15:0] capture_len,
   input  logic [7:0]  decim,
   output logic [31:0] fifo_wdata,
   output logic        fifo_wr_en,
   input  logic        fifo_full,
   output logic        busy,
   output logic        done,
   output logic        overflow,
   output logic [15:0] words_written
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_ARMED   = 2'd1;
   localparam logic [1:0] S_CAPTURE = 2'd2;
   localparam logic [1:0] S_DONE    = 2'd3;

   logic [1:0]  state;
   logic [15:0] len_q;
   logic [7:0]  decim_q;
   logic [7:0]  dcnt;

   logic        sample_ev;
   logic        accept;
   logic        last_word;
   logic [15:0] ww_inc;

   // Abort suppresses any event in the same cycle so nothing new is queued.
   always_comb begin
      sample_ev = 1'b0;
      if (!abort) begin
         if (state == S_ARMED && trig)
            sample_ev = 1'b1;
         else if (state == S_CAPTURE && dcnt == 8'd0)
            sample_ev = 1'b1;
      end
      accept    = sample_ev && !fifo_full;
      ww_inc    = words_written + 16'd1;
      last_word = accept && (len_q != 16'd0) && (ww_inc == len_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         len_q         <= 16'd0;
         decim_q       <= 8'd0;
         dcnt          <= 8'd0;
         fifo_wdata    <= 32'd0;
         fifo_wr_en    <= 1'b0;
         overflow      <= 1'b0;
         words_written <= 16'd0;
      end else begin
         fifo_wr_en <= accept;
         if (accept) begin
            fifo_wdata    <= {2'b00, adc_1_data, 2'b00, adc_2_data};
            words_written <= ww_inc;
         end
         if (sample_ev && fifo_full)
            overflow <= 1'b1;

         // Counter sits at 0 while armed, so the trigger cycle is an event.
         if (!abort && (state == S_CAPTURE || (state == S_ARMED && trig)))
            dcnt <= (dcnt == decim_q) ? 8'd0 : dcnt + 8'd1;

         if (abort) begin
            state <= S_IDLE;
            dcnt  <= 8'd0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start) begin
                     state         <= S_ARMED;
                     len_q         <= capture_len;
                     decim_q       <= decim;
                     dcnt          <= 8'd0;
                     words_written <= 16'd0;
                     overflow      <= 1'b0;
                  end
               end
               S_ARMED: begin
                  if (trig)
                     state <= last_word ? S_DONE : S_CAPTURE;
               end
               S_CAPTURE: begin
                  if (last_word)
                     state <= S_DONE;
               end
               S_DONE:  state <= S_IDLE;
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   assign busy = (state == S_ARMED) || (state == S_CAPTURE);
   assign done = (state == S_DONE);

endmodule
